// File: rtl/up_down_counter_bounded.sv
// ---------------------------------------------------------------------------
// up_down_counter_bounded
//
// General-purpose up/down counter with bounds [min_val, max_val] that can be
// changed at runtime. It supports a programmable step size, wrap or saturate
// behaviour at the bounds, a clamped load, boundary flags and sticky
// overflow/underflow flags. Intended uses are timers, address walkers and
// modulo sequencers.
//
// Parameters
//   WIDTH     : width of count, bounds and load value (>= 2)
//   STEP_W    : width of the step input (1..WIDTH)
//   RESET_VAL : count value after reset (not clamped into the bounds)
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous assert, active-high reset
//   enable     : advance the count by one step this cycle
//   up_down    : 1 = count up, 0 = count down
//   load       : load load_val this cycle, clamped into the bounds
//   load_val   : value to load
//   step       : step magnitude; 0 means hold
//   min_val    : inclusive unsigned lower bound
//   max_val    : inclusive unsigned upper bound
//   sat_mode   : 0 = wrap at the bound, 1 = saturate at the bound
//   clr_flags  : clear ovf_sticky and unf_sticky
//   count      : current count (registered)
//   at_max     : count == max_val
//   at_min     : count == min_val
//   bound_hit  : one-cycle pulse; the previous update wrapped or saturated
//   ovf_sticky : set by any up-direction bound event
//   unf_sticky : set by any down-direction bound event
//   cfg_err    : min_val > max_val
// ---------------------------------------------------------------------------
module up_down_counter_bounded #(
  parameter int               WIDTH     = 8,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              up_down,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              bound_hit,
  output logic              ovf_sticky,
  output logic              unf_sticky,
  output logic              cfg_err
);

  localparam int EW = WIDTH + 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             hit_q, hit_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             cfg_err_w;
  logic             step_nz;
  logic [WIDTH-1:0] step_w;
  logic [EW-1:0]    step_x;
  logic [EW-1:0]    count_x;
  logic [EW-1:0]    min_x;
  logic [EW-1:0]    max_x;
  logic [EW-1:0]    up_sum;
  logic [EW-1:0]    dn_floor;
  logic [WIDTH-1:0] dn_diff;
  logic             up_evt;
  logic             dn_evt;
  logic [WIDTH-1:0] load_clamped;
  logic             ovf_set;
  logic             unf_set;

  assign cfg_err_w = (min_val > max_val);
  assign step_nz   = |step;

  // All bound comparisons use one extra bit, so count+step can never wrap
  // silently. This also catches a count that already lies above max_val.
  assign step_w   = WIDTH'(step);
  assign step_x   = EW'(step);
  assign count_x  = EW'(count_q);
  assign min_x    = EW'(min_val);
  assign max_x    = EW'(max_val);
  assign up_sum   = count_x + step_x;
  assign dn_floor = min_x + step_x;
  assign up_evt   = (up_sum > max_x);
  // This test is count < min + step, written so the subtraction cannot
  // go negative. It also catches a count that lies below min_val.
  assign dn_evt   = (count_x < dn_floor);
  // Used only when dn_evt is clear, so it cannot underflow.
  assign dn_diff  = count_q - step_w;

  // Clamp the load value. With inverted bounds there is no valid range,
  // so the upper bound wins and the result never exceeds max_val.
  always_comb begin
    load_clamped = load_val;
    if (load_val > max_val) begin
      load_clamped = max_val;
    end else if (!cfg_err_w && (load_val < min_val)) begin
      load_clamped = min_val;
    end
  end

  // Next-state logic. Priority: load, then an enabled step, then hold.
  // A zero step or an inverted bound configuration makes enable a hold.
  always_comb begin
    count_d = count_q;
    hit_d   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (enable && step_nz && !cfg_err_w) begin
      if (up_down) begin
        if (up_evt) begin
          count_d = sat_mode ? max_val : min_val;
          hit_d   = 1'b1;
          ovf_set = 1'b1;
        end else begin
          count_d = up_sum[WIDTH-1:0];
        end
      end else begin
        if (dn_evt) begin
          count_d = sat_mode ? min_val : max_val;
          hit_d   = 1'b1;
          unf_set = 1'b1;
        end else begin
          count_d = dn_diff;
        end
      end
    end
  end

  // A set in the same cycle as a clear wins, so no bound event is lost.
  assign ovf_d = ovf_set | (ovf_q & ~clr_flags);
  assign unf_d = unf_set | (unf_q & ~clr_flags);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VAL;
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count      = count_q;
  assign at_max     = (count_q == max_val);
  assign at_min     = (count_q == min_val);
  assign bound_hit  = hit_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
  assign cfg_err    = cfg_err_w;

endmodule

// File: tb/tb_up_down_counter_bounded.sv
module tb_up_down_counter_bounded;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic [3:0] step = '0;
  logic [7:0] min_val = '0;
  logic [7:0] max_val = 8'd255;
  logic       sat_mode = 1'b0;
  logic       clr_flags = 1'b0;
  logic [7:0] count;
  logic       at_max, at_min, bound_hit, ovf_sticky, unf_sticky, cfg_err;

  up_down_counter_bounded #(.WIDTH(8), .STEP_W(4), .RESET_VAL(8'd0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_val(load_val), .step(step), .min_val(min_val), .max_val(max_val),
    .sat_mode(sat_mode), .clr_flags(clr_flags), .count(count), .at_max(at_max),
    .at_min(at_min), .bound_hit(bound_hit), .ovf_sticky(ovf_sticky),
    .unf_sticky(unf_sticky), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cnt;
    int hit;
    int ovf;
    int unf;
    int amax;
    int amin;
    int cerr;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   txn_id = 0;

  // Reference state, kept as plain integers.
  int m_count = 0;
  int m_ovf = 0;
  int m_unf = 0;

  task automatic chk(input string name, input int id, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL txn %0d %s: got %0d expected %0d", id, name, act, expv);
    end
  endtask

  // Reference model. It applies the counter rules to integers, so the
  // arithmetic has no width limit, and returns the expected outputs for
  // the edge that uses the current inputs.
  task automatic model(output exp_t e);
    int mn, mx, st, c, hit;
    bit bad;
    mn  = int'(min_val);
    mx  = int'(max_val);
    st  = int'(step);
    c   = m_count;
    hit = 0;
    bad = (mn > mx);
    if (load) begin
      c = int'(load_val);
      if (c > mx) c = mx;
      else if (!bad && c < mn) c = mn;
    end else if (enable && st != 0 && !bad) begin
      if (up_down) begin
        if (c + st > mx) begin
          hit = 1;
          c = sat_mode ? mx : mn;
        end else begin
          c = c + st;
        end
      end else begin
        if (c - st < mn) begin
          hit = 1;
          c = sat_mode ? mn : mx;
        end else begin
          c = c - st;
        end
      end
    end
    m_ovf = (hit && up_down) ? 1 : (clr_flags ? 0 : m_ovf);
    m_unf = (hit && !up_down) ? 1 : (clr_flags ? 0 : m_unf);
    m_count = c;
    e.id   = txn_id;
    e.cnt  = c;
    e.hit  = hit;
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    e.amax = (c == mx) ? 1 : 0;
    e.amin = (c == mn) ? 1 : 0;
    e.cerr = bad ? 1 : 0;
  endtask

  // Apply one cycle of stimulus at the falling edge and queue its expected result.
  task automatic cyc(input bit en, input bit ud, input bit ld, input int ldv,
                     input int st, input int mn, input int mx, input bit sat, input bit clr);
    exp_t e;
    @(negedge clk);
    enable    = en;
    up_down   = ud;
    load      = ld;
    load_val  = 8'(ldv);
    step      = 4'(st);
    min_val   = 8'(mn);
    max_val   = 8'(mx);
    sat_mode  = sat;
    clr_flags = clr;
    txn_id++;
    model(e);
    exp_q.push_back(e);
  endtask

  // Monitor: one queued result per clock, sampled just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("count", e.id, int'(count), e.cnt);
        chk("bound_hit", e.id, int'(bound_hit), e.hit);
        chk("ovf_sticky", e.id, int'(ovf_sticky), e.ovf);
        chk("unf_sticky", e.id, int'(unf_sticky), e.unf);
        chk("at_max", e.id, int'(at_max), e.amax);
        chk("at_min", e.id, int'(at_min), e.amin);
        chk("cfg_err", e.id, int'(cfg_err), e.cerr);
        $display("[TB] txn %0d count=%0d hit=%0b ovf=%0b unf=%0b", e.id, count,
                 bound_hit, ovf_sticky, unf_sticky);
      end
    end
  end

  initial begin
    int mn, mx, tmp;
    #1;
    chk("reset_count", 0, int'(count), 0);
    chk("reset_hit", 0, int'(bound_hit), 0);
    chk("reset_ovf", 0, int'(ovf_sticky), 0);
    chk("reset_unf", 0, int'(unf_sticky), 0);
    @(negedge clk);
    reset = 1'b0;

    // Up, wrap, step 3 from 18 in [10,20]: 21 > 20 wraps to 10, then 13.
    cyc(0, 1, 1, 18, 3, 10, 20, 0, 0);
    cyc(1, 1, 0, 0, 3, 10, 20, 0, 0);
    cyc(1, 1, 0, 0, 3, 10, 20, 0, 0);
    // Down, saturate, step 4 from 12: pins at 10 and pulses every cycle.
    cyc(0, 0, 1, 12, 4, 10, 20, 1, 1);
    cyc(1, 0, 0, 0, 4, 10, 20, 1, 0);
    cyc(1, 0, 0, 0, 4, 10, 20, 1, 0);
    cyc(1, 0, 0, 0, 4, 10, 20, 1, 0);
    // Load beats enable and is clamped to max_val.
    cyc(1, 1, 1, 25, 4, 10, 20, 1, 0);
    // Full range, 250 + 15 wraps to 0.
    cyc(0, 1, 1, 250, 15, 0, 255, 0, 1);
    cyc(1, 1, 0, 0, 15, 0, 255, 0, 0);
    // Inverted bounds: enabled counting holds and flags stay.
    cyc(1, 1, 0, 0, 5, 30, 5, 0, 0);
    cyc(1, 0, 0, 0, 5, 30, 5, 1, 0);
    cyc(0, 0, 1, 100, 5, 30, 5, 0, 0);
    // A clear together with a bound event leaves the sticky set; a plain clear clears it.
    cyc(0, 1, 1, 20, 3, 10, 20, 1, 0);
    cyc(1, 1, 0, 0, 3, 10, 20, 1, 1);
    cyc(0, 1, 0, 0, 3, 10, 20, 1, 1);
    // A zero step holds even when the count lies outside the bounds.
    cyc(1, 1, 0, 0, 0, 30, 40, 0, 0);

    // Reset in the middle of a count, asserted away from the clock edge.
    cyc(0, 1, 1, 8'h37, 1, 0, 255, 0, 0);
    @(negedge clk);
    load = 1'b0;
    enable = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_count", txn_id, int'(count), 0);
    chk("async_reset_hit", txn_id, int'(bound_hit), 0);
    chk("async_reset_ovf", txn_id, int'(ovf_sticky), 0);
    chk("async_reset_unf", txn_id, int'(unf_sticky), 0);
    @(negedge clk);
    reset = 1'b0;
    m_count = 0;
    m_ovf = 0;
    m_unf = 0;

    // Random traffic. The bounds change now and then, and are sometimes inverted.
    mn = 10;
    mx = 200;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        mn = $urandom_range(0, 255);
        mx = $urandom_range(mn, 255);
        if ($urandom_range(0, 7) == 0) begin
          tmp = mn;
          mn = mx;
          mx = tmp;
        end
      end
      cyc($urandom_range(0, 99) < 85, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 8, $urandom_range(0, 255),
          $urandom_range(0, 15), mn, mx, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0);
    end
    @(posedge clk);
    #2;
    chk("drain", txn_id, exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
